intr_ctrl: RTL
==============

// Module: intr_ctrl
// PURPOSE
//   Memory-mapped interrupt controller upstream of the CPU core. Latches rising edges on
//   NUM_SRC peripheral request lines, applies a mask, and picks the highest-priority
//   source (lowest index). Drives the core's irq/EAddr inputs and consumes its iack.
//   The ISR accesses its registers over the data-memory bus (alu_out/wd_dm/we_dm/rd_dm path).
// PARAMETERS
//   NUM_SRC     4             number of request sources (1..8)
//   BASE_ADDR   32'h0000_0900 register block base; 16-byte window, addr[31:4] match
//   VEC_BASE    32'h0000_0180 handler address for source 0
//   VEC_STRIDE  32'h0000_0020 spacing between per-source handler addresses
// PORTS
//   clk      in   1        system clock, all state on rising edge
//   rst      in   1        asynchronous, active-low reset
//   src_irq  in   NUM_SRC  peripheral requests, synchronous to clk, rising-edge significant
//   addr     in   32       bus byte address (core alu_out)
//   we       in   1        bus write enable (core we_dm)
//   wd       in   32       bus write data (core wd_dm)
//   rd       out  32       bus read data, combinational; 0 when window not selected
//   sel      out  1        addr inside register window (for the system read-data mux)
//   iack     in   1        one-cycle acknowledge from core
//   irq      out  1        interrupt request to core (registered)
//   EAddr    out  32       handler address of the granted source (registered)
// BEHAVIOUR
//   Register map (word offset addr[3:2]), writes only when sel && we:
//     0x0 PEND  R/W1C  bit i set on src_irq[i] rising edge; writing 1 clears bit i
//     0x4 MASK  R/W    bit i = 1 enables source i; reset 0 (all masked)
//     0x8 STAT  R      {28'b0, state[1:0], 2'b0} in bits [3:2] plus id in [7:4]; writes ignored
//     0xC EOI   W      any write ends service; reads return 0
//   Edge detect: src_q <= src_irq; edge = src_irq & ~src_q. Same-cycle edge and W1C on
//     the same bit -> set wins.
//   FSM (IDLE=0, REQ=1, SERV=2):
//     IDLE: if |(PEND&MASK): latch id = lowest set index; EAddr <= VEC_BASE+id*VEC_STRIDE;
//           irq <= 1; -> REQ.
//     REQ:  irq held 1, id/EAddr frozen even if MASK/PEND change. On iack: clear PEND[id]
//           (overrides a same-cycle new edge on that bit), irq <= 0, -> SERV.
//     SERV: irq 0; new edges keep accumulating in PEND. On EOI write -> IDLE; a new
//           request may assert irq on the very next edge.
//     iack in IDLE or SERV ignored; EOI write in IDLE or REQ ignored.
//   Latency: edge sampled at clk edge k -> PEND set after k -> irq=1 after k+1.
//   EAddr arithmetic is 32-bit unsigned with wrap; id width = clog2(NUM_SRC) (min 1).
//   Reset (any time, incl. mid-service): PEND=0, MASK=0, src_q=0, id=0, state=IDLE,
//     irq=0, EAddr=VEC_BASE. rd/sel are combinational and follow addr.
//   Unused high bits of PEND/MASK read 0; writes to them are ignored.
// STRUCTURE
//   intr_pkg: register offsets (OFF_PEND/MASK/STAT/EOI), FSM state localparams.
//   Sub-module intr_prio_enc: NUM_SRC-wide lowest-index-first encoder -> {valid, id}.
//   Top: edge detect, register file, FSM, read mux.
// TESTING
//   1 Reset: assert rst=0 mid-REQ -> irq=0, EAddr=0x180, PEND/MASK read 0 right away.
//   2 MASK=0xF, pulse src_irq[2] -> PEND=0x4 next cycle, irq=1 and EAddr=0x1C0 one cycle
//     later; iack -> PEND=0, irq=0, STAT state=SERV; write EOI -> IDLE.
//   3 Priority: MASK=0xF, edges on src 3 and 1 same cycle -> EAddr=0x1A0; after iack+EOI,
//     irq re-asserts with EAddr=0x1E0.
//   4 Masking: MASK=0, edge on src0 -> PEND=1, irq stays 0; write MASK=1 -> irq after 1 cycle.
//   5 Collisions: W1C PEND bit1 same cycle as src1 edge -> bit1 stays 1; iack same cycle
//     as a new edge on granted id -> bit cleared.
//   6 Bus: write to 0x0000_0A00 (outside window) -> no state change; sel=0, rd=0.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller:
// register word offsets and FSM states.
package intr_pkg;

   localparam logic [1:0] OFF_PEND = 2'd0;
   localparam logic [1:0] OFF_MASK = 2'd1;
   localparam logic [1:0] OFF_STAT = 2'd2;
   localparam logic [1:0] OFF_EOI  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_SERV = 2'd2
   } state_t;

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-first priority encoder.
// Bit 0 has the highest priority.
module intr_prio_enc #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   output logic           valid,
   output logic [IDW-1:0] id
);

   assign valid = |req;

   always_comb begin
      id = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) id = IDW'(i);
      end
   end

endmodule

// File: rtl/intr_ctrl.sv
// Memory-mapped interrupt controller: edge-latched pending bits,
// mask, priority grant and a REQ/SERV handshake with the core.
module intr_ctrl
   import intr_pkg::*;
#(
   parameter int          NUM_SRC    = 4,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0900,
   parameter logic [31:0] VEC_BASE   = 32'h0000_0180,
   parameter logic [31:0] VEC_STRIDE = 32'h0000_0020
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src_irq,
   input  logic [31:0]        addr,
   input  logic               we,
   input  logic [31:0]        wd,
   output logic [31:0]        rd,
   output logic               sel,
   input  logic               iack,
   output logic               irq,
   output logic [31:0]        EAddr
);

   localparam int IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [NUM_SRC-1:0] src_q;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] pend;
   logic [NUM_SRC-1:0] pend_n;
   logic [NUM_SRC-1:0] mask;
   logic [IDW-1:0]     id;
   logic [IDW-1:0]     pe_id;
   logic               pe_valid;
   state_t             state;
   state_t             state_n;
   logic [1:0]         off;
   logic               wr;
   logic               wr_pend;
   logic               wr_mask;
   logic               wr_eoi;
   logic               grant;
   logic               ack;
   logic               eoi;
   logic               unused_bits;

   assign unused_bits = ^{addr[1:0], wd};

   assign off     = addr[3:2];
   assign sel     = (addr[31:4] == BASE_ADDR[31:4]);
   assign wr      = sel & we;
   assign wr_pend = wr & (off == OFF_PEND);
   assign wr_mask = wr & (off == OFF_MASK);
   assign wr_eoi  = wr & (off == OFF_EOI);
   assign rise    = src_irq & ~src_q;

   intr_prio_enc #(
      .N   (NUM_SRC),
      .IDW (IDW)
   ) u_prio (
      .req   (pend & mask),
      .valid (pe_valid),
      .id    (pe_id)
   );

   // FSM: state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_n;
   end

   // FSM: next state
   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE:  if (pe_valid) state_n = S_REQ;
         S_REQ:   if (iack)     state_n = S_SERV;
         S_SERV:  if (wr_eoi)   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // FSM: per-state actions
   always_comb begin
      grant = 1'b0;
      ack   = 1'b0;
      eoi   = 1'b0;
      unique case (state)
         S_IDLE:  grant = pe_valid;
         S_REQ:   ack   = iack;
         S_SERV:  eoi   = wr_eoi;
         default: ;
      endcase
   end

   // New edges beat W1C; the acknowledge clear beats a new edge.
   always_comb begin
      pend_n = pend;
      if (wr_pend) pend_n = pend_n & ~wd[NUM_SRC-1:0];
      pend_n = pend_n | rise;
      if (ack) pend_n[id] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         src_q <= '0;
         pend  <= '0;
         mask  <= '0;
      end else begin
         src_q <= src_irq;
         pend  <= pend_n;
         if (wr_mask) mask <= wd[NUM_SRC-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         id    <= '0;
         irq   <= 1'b0;
         EAddr <= VEC_BASE;
      end else begin
         irq <= (state_n == S_REQ);
         if (grant) begin
            id    <= pe_id;
            EAddr <= VEC_BASE + 32'(pe_id) * VEC_STRIDE;
         end
      end
   end

   always_comb begin
      rd = '0;
      if (sel) begin
         unique case (off)
            OFF_PEND: rd = 32'(pend);
            OFF_MASK: rd = 32'(mask);
            OFF_STAT: rd = {24'b0, 4'(id), state, 2'b00};
            OFF_EOI:  rd = '0;
            default:  rd = '0;
         endcase
      end
   end

   logic eoi_seen;
   assign eoi_seen = eoi;

endmodule
